// File: rtl/fft_peak_rx_pkg.sv
// fft_rx_pkg: shared constants and types for the FFT peak receiver.
//   WIDTH_DEF  : default log2 of frame length
//   DATA_W_DEF : default bits per signed I/Q component
//   N_DEF      : default frame length in bins
//   MAG_W_DEF  : default magnitude width (re^2 + im^2 never overflows)
//   peak_state_t : compare-stage FSM states
package fft_rx_pkg;

  localparam int WIDTH_DEF  = 14;
  localparam int DATA_W_DEF = 16;
  localparam int N_DEF      = 1 << WIDTH_DEF;
  localparam int MAG_W_DEF  = 2 * DATA_W_DEF + 1;

  // EMPTY: no frame in progress, ACC: accumulating the running maximum
  typedef enum logic {
    EMPTY = 1'b0,
    ACC   = 1'b1
  } peak_state_t;

endpackage

// File: rtl/fft_peak_rx_if.sv
// fft_peak_rx_if: AXI-Stream style FFT output beat bus.
//   tdata  : {im, re}, each data_w bits two's complement
//   tvalid : beat valid (master -> slave)
//   tlast  : upstream end-of-frame marker (master -> slave)
//   tready : beat accept (slave -> master); transfer on tvalid & tready
interface fft_peak_rx_if
  import fft_rx_pkg::*;
#(
  parameter int data_w = DATA_W_DEF
) ();

  logic [2*data_w-1:0] tdata;
  logic                tvalid;
  logic                tlast;
  logic                tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/fft_peak_rx_mag_sq.sv
// fft_mag_sq: two-stage squared-magnitude pipeline.
//   Stage 1 registers re*re and im*im, stage 2 registers their sum.
//   A sideband vector and valid flag travel alongside the data.
// Ports:
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   i_valid, i_sb   : input beat valid and sideband
//   i_re, i_im      : signed components
//   o_valid, o_sb   : pipelined valid and sideband (2 cycles later)
//   o_mag           : unsigned re^2 + im^2, full precision
module fft_mag_sq
  import fft_rx_pkg::*;
#(
  parameter int data_w = DATA_W_DEF,
  parameter int sb_w   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [data_w-1:0] i_re,
  input  logic [data_w-1:0] i_im,
  input  logic [sb_w-1:0]   i_sb,
  output logic              o_valid,
  output logic [2*data_w:0] o_mag,
  output logic [sb_w-1:0]   o_sb
);

  // Sign-extend to product width so the square is computed exactly;
  // the square of a data_w-bit signed value always fits 2*data_w unsigned bits.
  logic signed [2*data_w-1:0] w_re_ext;
  logic signed [2*data_w-1:0] w_im_ext;
  assign w_re_ext = {{data_w{i_re[data_w-1]}}, i_re};
  assign w_im_ext = {{data_w{i_im[data_w-1]}}, i_im};

  logic                r_s1_valid;
  logic [2*data_w-1:0] r_re_sq;
  logic [2*data_w-1:0] r_im_sq;
  logic [sb_w-1:0]     r_s1_sb;
  logic                r_s2_valid;
  logic [2*data_w:0]   r_mag;
  logic [sb_w-1:0]     r_s2_sb;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_re_sq    <= '0;
      r_im_sq    <= '0;
      r_s1_sb    <= '0;
      r_s2_valid <= 1'b0;
      r_mag      <= '0;
      r_s2_sb    <= '0;
    end else begin
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_re_sq <= w_re_ext * w_re_ext;
        r_im_sq <= w_im_ext * w_im_ext;
        r_s1_sb <= i_sb;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_mag   <= {1'b0, r_re_sq} + {1'b0, r_im_sq};
        r_s2_sb <= r_s1_sb;
      end
    end
  end

  assign o_valid = r_s2_valid;
  assign o_mag   = r_mag;
  assign o_sb    = r_s2_sb;

endmodule

// File: rtl/fft_peak_rx.sv
// fft_peak_rx: finds the strongest bin of each FFT frame.
//   Beats are tagged with a bin index, squared-magnitude is pipelined, and a
//   compare stage tracks the per-frame maximum (lowest bin wins ties).
//   A frame closes on bin N-1 or tlast; the result appears 3 cycles after
//   the closing beat is accepted.
// Ports:
//   clk_cntr, rst_cntr : clock, asynchronous active-high reset
//   s_axis             : beat input bus (slave side)
//   hold               : backpressure request, reflected on tready a cycle later
//   peak_valid         : one-cycle result pulse
//   peak_bin, peak_mag : result, held between pulses
//   err_tlast_early    : tlast seen before bin N-1 (with peak_valid)
//   err_tlast_missing  : bin N-1 without tlast (with peak_valid)
//   frame_cnt          : closed-frame counter, wraps
module fft_peak_rx
  import fft_rx_pkg::*;
#(
  parameter int width  = WIDTH_DEF,
  parameter int data_w = DATA_W_DEF
) (
  input  logic               clk_cntr,
  input  logic               rst_cntr,
  fft_peak_rx_if.slave       s_axis,
  input  logic               hold,
  output logic               peak_valid,
  output logic [width-1:0]   peak_bin,
  output logic [2*data_w:0]  peak_mag,
  output logic               err_tlast_early,
  output logic               err_tlast_missing,
  output logic [15:0]        frame_cnt
);

  // sideband layout: {bin, first, close, early, missing}
  localparam int SB_W = width + 4;
  localparam logic [width-1:0] LAST_BIN = '1;

  // ---------------- input / bin-tagging stage ----------------
  logic              r_tready;
  logic [width-1:0]  r_bin;
  logic              r_in_valid;
  logic [data_w-1:0] r_in_re;
  logic [data_w-1:0] r_in_im;
  logic [SB_W-1:0]   r_in_sb;

  logic w_accept;
  logic w_last_bin;
  logic w_close;
  assign w_accept   = s_axis.tvalid & r_tready;
  assign w_last_bin = (r_bin == LAST_BIN);
  assign w_close    = w_last_bin | s_axis.tlast;

  assign s_axis.tready = r_tready;

  always_ff @(posedge clk_cntr or posedge rst_cntr) begin
    if (rst_cntr) begin
      r_tready   <= 1'b0;
      r_bin      <= '0;
      r_in_valid <= 1'b0;
      r_in_re    <= '0;
      r_in_im    <= '0;
      r_in_sb    <= '0;
    end else begin
      r_tready   <= ~hold;
      r_in_valid <= w_accept;
      if (w_accept) begin
        r_in_re <= s_axis.tdata[data_w-1:0];
        r_in_im <= s_axis.tdata[2*data_w-1:data_w];
        r_in_sb <= {r_bin, (r_bin == '0), w_close,
                    s_axis.tlast & ~w_last_bin, w_last_bin & ~s_axis.tlast};
        // closing beat rewinds so a back-to-back frame starts at bin 0
        r_bin   <= w_close ? '0 : r_bin + width'(1);
      end
    end
  end

  // ---------------- magnitude pipeline ----------------
  logic              w_mag_valid;
  logic [2*data_w:0] w_mag;
  logic [SB_W-1:0]   w_mag_sb;

  fft_mag_sq #(
    .data_w (data_w),
    .sb_w   (SB_W)
  ) u_mag_sq (
    .i_clk   (clk_cntr),
    .i_rst   (rst_cntr),
    .i_valid (r_in_valid),
    .i_re    (r_in_re),
    .i_im    (r_in_im),
    .i_sb    (r_in_sb),
    .o_valid (w_mag_valid),
    .o_mag   (w_mag),
    .o_sb    (w_mag_sb)
  );

  logic [width-1:0] w_p_bin;
  logic             w_p_first;
  logic             w_p_close;
  logic             w_p_early;
  logic             w_p_missing;
  assign {w_p_bin, w_p_first, w_p_close, w_p_early, w_p_missing} = w_mag_sb;

  // ---------------- compare stage ----------------
  peak_state_t       r_state;
  logic [width-1:0]  r_acc_bin;
  logic [2*data_w:0] r_acc_mag;
  logic              r_peak_valid;
  logic [width-1:0]  r_peak_bin;
  logic [2*data_w:0] r_peak_mag;
  logic              r_err_early;
  logic              r_err_missing;
  logic [15:0]       r_frame_cnt;

  // First beat of a frame loads unconditionally; later beats must be
  // strictly greater, so ties keep the earlier (lower) bin.
  logic              w_take;
  logic [width-1:0]  w_best_bin;
  logic [2*data_w:0] w_best_mag;
  assign w_take     = (r_state == EMPTY) || w_p_first || (w_mag > r_acc_mag);
  assign w_best_bin = w_take ? w_p_bin : r_acc_bin;
  assign w_best_mag = w_take ? w_mag : r_acc_mag;

  always_ff @(posedge clk_cntr or posedge rst_cntr) begin
    if (rst_cntr) begin
      r_state       <= EMPTY;
      r_acc_bin     <= '0;
      r_acc_mag     <= '0;
      r_peak_valid  <= 1'b0;
      r_peak_bin    <= '0;
      r_peak_mag    <= '0;
      r_err_early   <= 1'b0;
      r_err_missing <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_peak_valid  <= 1'b0;
      r_err_early   <= 1'b0;
      r_err_missing <= 1'b0;
      if (w_mag_valid) begin
        if (w_p_close) begin
          r_peak_valid  <= 1'b1;
          r_peak_bin    <= w_best_bin;
          r_peak_mag    <= w_best_mag;
          r_err_early   <= w_p_early;
          r_err_missing <= w_p_missing;
          r_frame_cnt   <= r_frame_cnt + 16'd1;
          r_state       <= EMPTY;
        end else begin
          r_acc_bin <= w_best_bin;
          r_acc_mag <= w_best_mag;
          r_state   <= ACC;
        end
      end
    end
  end

  assign peak_valid        = r_peak_valid;
  assign peak_bin          = r_peak_bin;
  assign peak_mag          = r_peak_mag;
  assign err_tlast_early   = r_err_early;
  assign err_tlast_missing = r_err_missing;
  assign frame_cnt         = r_frame_cnt;

endmodule

// File: tb/tb_fft_peak_rx.sv
// tb_fft_peak_rx: scoreboard bench for fft_peak_rx.
//   The driver computes each frame's expected result from its own arithmetic
//   and queues it with the cycle it must appear in; a negedge monitor pops and
//   compares whenever peak_valid pulses.
module tb_fft_peak_rx;
  import fft_rx_pkg::*;

  localparam int W  = 14;
  localparam int DW = 16;
  localparam int NB = 1 << W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            hold = 1'b0;
  logic            peak_valid;
  logic [W-1:0]    peak_bin;
  logic [2*DW:0]   peak_mag;
  logic            err_early;
  logic            err_missing;
  logic [15:0]     frame_cnt;

  fft_peak_rx_if #(.data_w(DW)) bus ();

  fft_peak_rx #(.width(W), .data_w(DW)) u_dut (
    .clk_cntr          (clk),
    .rst_cntr          (rst),
    .s_axis            (bus),
    .hold              (hold),
    .peak_valid        (peak_valid),
    .peak_bin          (peak_bin),
    .peak_mag          (peak_mag),
    .err_tlast_early   (err_early),
    .err_tlast_missing (err_missing),
    .frame_cnt         (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     cyc;
    int     bin;
    longint mag;
    bit     early;
    bit     missing;
    int     fc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e_cur;
  int          n_vec = 0;
  int          n_err = 0;
  bit          gaps_en = 1'b0;
  int          exp_fc = 0;
  logic [15:0] fre[NB];
  logic [15:0] fim[NB];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0]  last_bin = '0;
  logic [2*DW:0] last_mag = '0;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_tready", 64'(bus.tready), 64'd0);
      check("rst_peak_valid", 64'(peak_valid), 64'd0);
      check("rst_peak_bin", 64'(peak_bin), 64'd0);
      check("rst_peak_mag", 64'(peak_mag), 64'd0);
      check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      last_bin = '0;
      last_mag = '0;
    end else if (peak_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_peak", 64'd1, 64'd0);
      end else begin
        e_cur = sb_q.pop_front();
        $display("frame %0d: bin=%0d mag=%0d early=%0b missing=%0b at cycle %0d",
                 frame_cnt, peak_bin, peak_mag, err_early, err_missing, cyc);
        check("latency", 64'(cyc), 64'(e_cur.cyc));
        check("peak_bin", 64'(peak_bin), 64'(e_cur.bin));
        check("peak_mag", 64'(peak_mag), 64'(e_cur.mag));
        check("err_early", 64'(err_early), 64'(e_cur.early));
        check("err_missing", 64'(err_missing), 64'(e_cur.missing));
        check("frame_cnt", 64'(frame_cnt), 64'(e_cur.fc));
      end
      last_bin = peak_bin;
      last_mag = peak_mag;
    end else begin
      if (err_early)   check("stray_err_early", 64'(err_early), 64'd0);
      if (err_missing) check("stray_err_missing", 64'(err_missing), 64'd0);
      if (peak_bin !== last_bin) check("hold_peak_bin", 64'(peak_bin), 64'(last_bin));
      if (peak_mag !== last_mag) check("hold_peak_mag", 64'(peak_mag), 64'(last_mag));
      if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
        check("late_peak", 64'(cyc), 64'(sb_q[0].cyc));
        void'(sb_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send_beat(input logic [15:0] re, input logic [15:0] im,
                           input logic last, output int drive_cyc);
    bit done  = 1'b0;
    int guard = 0;
    drive_cyc = 0;
    while (!done) begin
      @(negedge clk);
      if (gaps_en) hold = ($urandom_range(0, 3) == 0);
      if (gaps_en && $urandom_range(0, 3) == 0) begin
        bus.tvalid = 1'b0;
        bus.tlast  = 1'b0;
      end else begin
        bus.tdata  = {im, re};
        bus.tlast  = last;
        bus.tvalid = 1'b1;
        // tready only changes on posedge, so this is the value the next edge sees
        if (bus.tready) begin
          done      = 1'b1;
          drive_cyc = cyc;
        end
      end
      guard++;
      if (!done && guard > 1000) begin
        check("tready_timeout", 64'd0, 64'd1);
        done = 1'b1;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.tvalid = 1'b0;
    bus.tlast  = 1'b0;
  endtask

  task automatic clear_frame();
    for (int i = 0; i < NB; i++) begin
      fre[i] = '0;
      fim[i] = '0;
    end
  endtask

  task automatic run_frame(input int nbeats, input bit tlast_final);
    int     best_bin = 0;
    longint best_mag = -1;
    int     dc;
    for (int i = 0; i < nbeats; i++) begin
      longint r = longint'($signed(fre[i]));
      longint q = longint'($signed(fim[i]));
      longint m = r * r + q * q;
      bit     last = tlast_final && (i == nbeats - 1);
      if (m > best_mag) begin
        best_mag = m;
        best_bin = i;
      end
      send_beat(fre[i], fim[i], last, dc);
      if (i == NB - 1 || last) begin
        exp_t e;
        exp_fc    = (exp_fc + 1) & 16'hFFFF;
        e.cyc     = dc + 4;
        e.bin     = best_bin;
        e.mag     = best_mag;
        e.early   = last && (i != NB - 1);
        e.missing = (i == NB - 1) && !last;
        e.fc      = exp_fc;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (sb_q.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic randomize_frame(input int n);
    for (int i = 0; i < n; i++) begin
      fre[i] = 16'($urandom);
      fim[i] = 16'($urandom);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.tvalid = 1'b0;
    bus.tlast  = 1'b0;
    bus.tdata  = '0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;

    // single tone at bin 100, proper tlast on the final bin
    clear_frame();
    fre[100] = 16'd3;
    fim[100] = 16'hFFFC;
    run_frame(NB, 1'b1);

    // equal magnitudes at bins 5 and 9: lower bin wins; short frame -> early
    clear_frame();
    fre[5] = 16'd5; fim[5] = 16'd5;
    fre[9] = 16'd5; fim[9] = 16'd5;
    run_frame(12, 1'b1);

    // tlast on bin 999
    clear_frame();
    fre[500] = 16'd100;
    run_frame(1000, 1'b1);

    // following frame must restart at bin 0
    clear_frame();
    fre[0] = 16'd7;
    fre[3] = 16'd9;
    run_frame(6, 1'b1);

    // full frame without tlast
    clear_frame();
    fre[16000] = 16'hFFFE;
    fim[16000] = 16'd1;
    run_frame(NB, 1'b0);

    // next beat after a missing-tlast close is bin 0
    clear_frame();
    fre[2] = 16'd1000;
    run_frame(4, 1'b1);

    // most negative components give the largest magnitude 2^31
    clear_frame();
    fre[0] = 16'h8000; fim[0] = 16'h8000;
    fre[1] = 16'h7FFF; fim[1] = 16'h7FFF;
    run_frame(4, 1'b1);
    idle();
    drain();

    // same random frame gap-free and with gaps / hold toggling
    randomize_frame(2000);
    run_frame(2000, 1'b1);
    gaps_en = 1'b1;
    run_frame(2000, 1'b1);
    gaps_en = 1'b0;
    hold    = 1'b0;
    idle();
    drain();

    // reset in the middle of a frame (after bin 5000)
    clear_frame();
    fre[10] = 16'd50;
    run_frame(5001, 1'b0);
    idle();
    @(posedge clk); #2 rst = 1'b1;
    exp_fc = 0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check("fc_after_rst", 64'(frame_cnt), 64'd0);

    randomize_frame(300);
    run_frame(300, 1'b1);
    idle();
    drain();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
